// File: rtl/bitcount_pkg.sv
// Shared types and helpers for the bit_count_asm one-bit counter.
// The fixed-latency variant is selected with BITCOUNT_FIXED_LATENCY_EN.
package bitcount_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COUNT,
        S_DONE
    } state_t;

    function automatic int cw_of(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/bit_count_asm_upcount.sv
// Generic up-counter with synchronous clear taking priority over enable.
// Used for the B result and the optional fixed-latency step counter.
module upcount #(
    parameter int W = 4
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] Q
);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            Q <= '0;
        end else if (clr) begin
            Q <= '0;
        end else if (en) begin
            Q <= Q + W'(1);
        end
    end

endmodule

// File: rtl/bit_count_asm.sv
// ASM bit counter: captures A, shifts MSB-first and counts ones into B.
// Define BITCOUNT_FIXED_LATENCY_EN for a constant N-cycle count phase.
module bit_count_asm
    import bitcount_pkg::*;
#(
    parameter  int N  = 8,
    localparam int CW = cw_of(N)
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic [N-1:0]  A,
    input  logic          s,
    output logic [CW-1:0] B,
    output logic          Done
);

    state_t       state;
    logic [N-1:0] Q;
    logic         b_clr;
    logic         b_en;
    logic         last;

`ifdef BITCOUNT_FIXED_LATENCY_EN
    localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

    logic [CW-1:0] step;

    upcount #(
        .W(CW)
    ) u_step (
        .Clock(Clock),
        .Reset(Reset),
        .clr  (state != S_COUNT),
        .en   (state == S_COUNT),
        .Q    (step)
    );

    // Exit after the N-th shift, whatever the data looks like.
    assign last = (step == LAST_STEP);
    assign b_en = (state == S_COUNT) && Q[N-1];
`else
    // Nothing left to count once the register is empty.
    assign last = (Q == '0);
    assign b_en = (state == S_COUNT) && !last && Q[N-1];
`endif

    assign b_clr = (state == S_IDLE) || ((state == S_DONE) && !s);

    upcount #(
        .W(CW)
    ) u_b (
        .Clock(Clock),
        .Reset(Reset),
        .clr  (b_clr),
        .en   (b_en),
        .Q    (B)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= S_IDLE;
            Q     <= '0;
            Done  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    Q    <= A;
                    Done <= 1'b0;
                    if (s) begin
                        state <= S_COUNT;
                    end
                end
                S_COUNT: begin
`ifdef BITCOUNT_FIXED_LATENCY_EN
                    Q <= {Q[N-2:0], 1'b0};
                    if (last) begin
                        state <= S_DONE;
                        Done  <= 1'b1;
                    end
`else
                    if (last) begin
                        state <= S_DONE;
                        Done  <= 1'b1;
                    end else begin
                        Q <= {Q[N-2:0], 1'b0};
                    end
`endif
                end
                S_DONE: begin
                    // Hold the result until the requester lets go of s.
                    if (!s) begin
                        state <= S_IDLE;
                        Done  <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    Done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bit_count_asm.sv
// Self-checking bench for bit_count_asm: vector table, corner sequences
// and random words against a popcount/latency reference model.
module tb_bit_count_asm;

    localparam int N  = 8;
    localparam int CW = $clog2(N + 1);

    logic          Clock = 1'b0;
    logic          Reset = 1'b1;
    logic [N-1:0]  A     = '0;
    logic          s     = 1'b0;
    logic [CW-1:0] B;
    logic          Done;

    int vectors    = 0;
    int miscompares = 0;

    bit_count_asm #(.N(N)) dut (
        .Clock(Clock),
        .Reset(Reset),
        .A    (A),
        .s    (s),
        .B    (B),
        .Done (Done)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [7:0] a;
        bit         pulse;
        int         exp_b;
        int         exp_early;
    } vec_t;

    function automatic int lat_sel(input int early);
`ifdef BITCOUNT_FIXED_LATENCY_EN
        return N;
`else
        return early;
`endif
    endfunction

    // Reference: plain popcount, and count-phase length from lowest set bit.
    task automatic model(input logic [N-1:0] a, output int b, output int lat);
        int low;
        b   = 0;
        low = -1;
        for (int i = 0; i < N; i++) begin
            if (a[i]) begin
                b++;
                if (low < 0) low = i;
            end
        end
        lat = lat_sel((low < 0) ? 1 : (N - low + 1));
    endtask

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called #1 after the edge that entered S_COUNT.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!Done && lat < 40) begin
            @(posedge Clock);
            #1;
            lat++;
        end
    endtask

    task automatic run(input logic [N-1:0] a, input bit pulse,
                       input int exp_b, input int exp_lat,
                       input string tag);
        int lat;
        @(negedge Clock);
        A = a;
        s = 1'b1;
        @(posedge Clock);
        #1;
        chk({tag, " done_low_in_count"}, int'(Done), 0);
        if (pulse) begin
            s = 1'b0;
            A = ~a;
        end
        wait_done(lat);
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " B"}, int'(B), exp_b);
        if (!pulse) begin
            @(posedge Clock);
            #1;
            chk({tag, " done_hold"}, int'(Done), 1);
            chk({tag, " B_hold"}, int'(B), exp_b);
            @(negedge Clock);
            s = 1'b0;
        end
        @(posedge Clock);
        #1;
        chk({tag, " done_clear"}, int'(Done), 0);
        chk({tag, " B_clear"}, int'(B), 0);
    endtask

    initial begin
        vec_t tbl[6];
        int   lat;
        int   eb;
        int   el;
        logic [N-1:0] r;

        tbl[0] = '{8'hA5, 1'b0, 4, 9};
        tbl[1] = '{8'h00, 1'b0, 0, 1};
        tbl[2] = '{8'h80, 1'b0, 1, 2};
        tbl[3] = '{8'hFF, 1'b0, 8, 9};
        tbl[4] = '{8'h01, 1'b0, 1, 9};
        tbl[5] = '{8'h0F, 1'b1, 4, 9};

        #12;
        chk("reset B", int'(B), 0);
        chk("reset Done", int'(Done), 0);
        @(negedge Clock);
        Reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run(tbl[i].a, tbl[i].pulse, tbl[i].exp_b,
                lat_sel(tbl[i].exp_early), $sformatf("tbl%0d", i));
        end

        // Asynchronous reset three cycles into a count.
        @(negedge Clock);
        A = 8'hF0;
        s = 1'b1;
        @(posedge Clock);
        repeat (3) @(posedge Clock);
        #2;
        chk("midcount B_nonzero", int'(B != 0), 1);
        Reset = 1'b1;
        #1;
        chk("async B", int'(B), 0);
        chk("async Done", int'(Done), 0);
        s = 1'b0;
        @(negedge Clock);
        Reset = 1'b0;
        @(posedge Clock);
        #1;
        chk("post_reset idle", int'(Done), 0);
        run(8'hF0, 1'b0, 4, lat_sel(5), "restart");

        // s held after Done: no second count until s drops.
        @(negedge Clock);
        A = 8'h81;
        s = 1'b1;
        @(posedge Clock);
        #1;
        wait_done(lat);
        chk("held B", int'(B), 2);
        A = 8'hFF;
        for (int k = 0; k < 4; k++) begin
            @(posedge Clock);
            #1;
            chk("held Done", int'(Done), 1);
            chk("held B_stable", int'(B), 2);
        end
        @(negedge Clock);
        s = 1'b0;
        @(posedge Clock);
        #1;
        chk("low_phase Done", int'(Done), 0);
        @(negedge Clock);
        A = 8'h03;
        s = 1'b1;
        @(posedge Clock);
        #1;
        wait_done(lat);
        chk("second latency", lat, lat_sel(9));
        chk("second B", int'(B), 2);
        @(negedge Clock);
        s = 1'b0;
        @(posedge Clock);

        for (int i = 0; i < 30; i++) begin
            r = N'($urandom);
            model(r, eb, el);
            run(r, 1'($urandom_range(0, 1)), eb, el,
                $sformatf("rnd%0d_%02h", i, r));
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
